freq_meter_multi: RTL and testbench

FREQ_METER_MULTI -- requirements
Module: freq_meter_multi

---
 rtl/freq_meter_pkg.sv | 23 ++
 rtl/freq_edge_cnt.sv | 54 +++++
 rtl/freq_meter_multi.sv | 129 ++++++++++++
 tb/tb_freq_meter_multi.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared FSM encoding, gate divisors and gate-length helper for freq_meter_multi.
// Optional overflow reporting is enabled by defining FREQ_METER_OVF_EN.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } meter_state_t;

    localparam int GATE_DIV_0 = 1;
    localparam int GATE_DIV_1 = 10;
    localparam int GATE_DIV_2 = 100;
    localparam int GATE_DIV_3 = 1000;

    // A divided gate shorter than one cycle would never close, so clamp to 1.
    function automatic int gate_len_calc(input int cycles, input int div);
        int q;
        q = cycles / div;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/freq_edge_cnt.sv
// One measurement channel: input synchroniser, rising-edge detect and a
// saturating edge counter with synchronous clear.
module freq_edge_cnt
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_async,
    input  logic             count_en,
    input  logic             clear,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic [CNT_W-1:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Clear wins over counting so rises seen outside an open gate are dropped.
    always_comb begin
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (count_en && rise && (count_q != CNT_MAX)) begin
            count_next = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/freq_meter_multi.sv
// Multi-channel gated frequency meter; counts rising edges per channel over a
// selectable gate. Define FREQ_METER_OVF_EN to add the per-channel ovf output.
module freq_meter_multi
    import freq_meter_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 28,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [CH_NUM-1:0]       test_in,
    input  logic                    run,
    input  logic [1:0]              gate_sel,
    output logic [CH_NUM*CNT_W-1:0] freq_data,
    output logic                    freq_valid,
`ifdef FREQ_METER_OVF_EN
    output logic [CH_NUM-1:0]       ovf,
`endif
    output logic                    busy
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0] LEN0 = GW'(gate_len_calc(GATE_CYCLES, GATE_DIV_0));
    localparam logic [GW-1:0] LEN1 = GW'(gate_len_calc(GATE_CYCLES, GATE_DIV_1));
    localparam logic [GW-1:0] LEN2 = GW'(gate_len_calc(GATE_CYCLES, GATE_DIV_2));
    localparam logic [GW-1:0] LEN3 = GW'(gate_len_calc(GATE_CYCLES, GATE_DIV_3));

    meter_state_t              state, next_state;
    logic [GW-1:0]             gate_cnt, gate_len, sel_len;
    logic                      gate_done, start_gate, latch_now;
    logic [CH_NUM*CNT_W-1:0]   count_bus;
    logic [CH_NUM*CNT_W-1:0]   freq_data_q;

    assign gate_done  = (gate_cnt == gate_len - 1'b1);
    assign start_gate = ((state == IDLE) || (state == LATCH)) && run;
    assign latch_now  = (state == GATE) && run && gate_done;

    always_comb begin
        sel_len = LEN0;
        case (gate_sel)
            2'd1: sel_len = LEN1;
            2'd2: sel_len = LEN2;
            2'd3: sel_len = LEN3;
            default: sel_len = LEN0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping run aborts an open gate even on its final cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = GATE;
            GATE: begin
                if (!run)           next_state = IDLE;
                else if (gate_done) next_state = LATCH;
            end
            LATCH:   next_state = run ? GATE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gate_cnt <= '0;
            gate_len <= '0;
        end else if (start_gate) begin
            gate_cnt <= '0;
            gate_len <= sel_len;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        freq_edge_cnt #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .clk        (sys_clk),
            .rst_n      (sys_rst_n),
            .sig_async  (test_in[k]),
            .count_en   (state == GATE),
            .clear      (state != GATE),
            .count_next (count_bus[k*CNT_W +: CNT_W])
        );
    end

    // Capturing the next-count values includes rises from the final gate cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            freq_data_q <= '0;
        end else if (latch_now) begin
            freq_data_q <= count_bus;
        end
    end

`ifdef FREQ_METER_OVF_EN
    logic [CH_NUM-1:0] sat_now, ovf_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_sat
        assign sat_now[k] = &count_bus[k*CNT_W +: CNT_W];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovf_q <= '0;
        end else if (latch_now) begin
            ovf_q <= sat_now;
        end
    end

    assign ovf = ovf_q;
`endif

    assign freq_data  = freq_data_q;
    assign freq_valid = (state == LATCH);
    assign busy       = (state == GATE);

endmodule

// File: tb/tb_freq_meter_multi.sv
// Self-checking bench for freq_meter_multi: randomized channel activity scored
// against an edge-history model. Honours FREQ_METER_OVF_EN when defined.
module tb_freq_meter_multi;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int GC = 1000;
    localparam int SS = 2;
    localparam int NH = 20000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        run;
    logic [3:0]  test_in;
    logic [1:0]  gate_sel;
    logic [31:0] freq_data;
    logic        freq_valid;
    logic        busy;
`ifdef FREQ_METER_OVF_EN
    logic [3:0]  ovf;
`endif

    freq_meter_multi #(
        .CH_NUM      (CH),
        .CNT_W       (CW),
        .GATE_CYCLES (GC),
        .SYNC_STAGES (SS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .test_in    (test_in),
        .run        (run),
        .gate_sel   (gate_sel),
        .freq_data  (freq_data),
        .freq_valid (freq_valid),
`ifdef FREQ_METER_OVF_EN
        .ovf        (ovf),
`endif
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int          cyc = 0;
    bit [3:0]    hist [NH];
    int          n_tests = 0;
    int          n_fail = 0;
    int          mode [4];
    int          per [4];
    int          gate_e;
    logic [31:0] last_exp;

    // Input value seen by each rising edge; reset forces the synchronisers low.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < NH) hist[cyc + 1] <= sys_rst_n ? test_in : 4'b0;
    end

    // Rises sampled at edge t reach the counter at edge t+SS; count those landing in [lo,hi].
    function automatic int rises(input int ch, input int lo, input int hi);
        int n = 0;
        for (int t = lo - SS; t <= hi - SS; t++) begin
            if (t >= 1 && t < NH && hist[t][ch] && !hist[t-1][ch]) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] expData(input int lo, input int hi);
        logic [31:0] d;
        int n;
        d = '0;
        for (int ch = 0; ch < CH; ch++) begin
            n = rises(ch, lo, hi);
            d[ch*CW +: CW] = (n > 255) ? 8'd255 : 8'(n);
        end
        return d;
    endfunction

    function automatic logic [3:0] expOvf(input int lo, input int hi);
        logic [3:0] o;
        for (int ch = 0; ch < CH; ch++) o[ch] = (rises(ch, lo, hi) >= 255);
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int ch = 0; ch < CH; ch++) begin
            case (mode[ch])
                1:       test_in[ch] = 1'b1;
                2:       test_in[ch] = ((cyc % per[ch]) == 0);
                3:       test_in[ch] = 1'($urandom_range(0, 1));
                4:       test_in[ch] = ~test_in[ch];
                default: test_in[ch] = 1'b0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            applyStimulus();
        end
    endtask

    task automatic startRun(input logic [1:0] sel);
        @(negedge sys_clk);
        gate_sel = sel;
        run      = 1'b1;
        gate_e   = cyc + 1;
        applyStimulus();
    endtask

    task automatic runGate(input string tag, input int len, input bit stop, input logic [1:0] next_sel,
                           input int chg_k, input logic [1:0] chg_sel, input bit quiet);
        bit early = 1'b0;
        for (int k = 0; k <= len; k++) begin
            @(negedge sys_clk);
            if (k == 0) begin
                checkOutput({tag, "_busy"}, busy, 1'b1);
                checkOutput({tag, "_valid_low"}, freq_valid, 1'b0);
            end
            if (k < len && freq_valid) early = 1'b1;
            if (k == chg_k) gate_sel = chg_sel;
            if (k == len) begin
                last_exp = expData(gate_e + 1, gate_e + len);
                checkOutput({tag, "_valid"}, freq_valid, 1'b1);
                checkOutput({tag, "_early"}, early, 1'b0);
                checkOutput({tag, "_data"}, freq_data, last_exp);
`ifdef FREQ_METER_OVF_EN
                checkOutput({tag, "_ovf"}, ovf, expOvf(gate_e + 1, gate_e + len));
`endif
                gate_sel = next_sel;
                if (stop) run = 1'b0;
                if (quiet) for (int ch = 0; ch < CH; ch++) mode[ch] = 0;
                gate_e = gate_e + len + 1;
            end
            applyStimulus();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit seen;
        logic [31:0] prev;
        sys_rst_n = 1'b0;
        run       = 1'b0;
        gate_sel  = 2'd0;
        test_in   = 4'b0;
        for (int ch = 0; ch < CH; ch++) begin
            mode[ch] = 0;
            per[ch]  = 1;
        end
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_data", freq_data, 32'd0);
        checkOutput("rst_valid", freq_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
`ifdef FREQ_METER_OVF_EN
        checkOutput("rst_ovf", ovf, 4'd0);
`endif
        sys_rst_n = 1'b1;
        idle(3);

        // Periodic pulses on ch0/ch1 over 100-cycle gates.
        mode[0] = 2; per[0] = 5;
        mode[1] = 2; per[1] = 4;
        idle(5);
        startRun(2'd1);
        runGate("pulse_g1", 100, 1'b0, 2'd1, -1, 2'd0, 1'b0);
        runGate("pulse_g2", 100, 1'b0, 2'd1, -1, 2'd0, 1'b0);
        checkOutput("pulse_ch0", freq_data[7:0], 8'd20);
        checkOutput("pulse_ch1", freq_data[15:8], 8'd25);
        checkOutput("pulse_ch23", freq_data[31:16], 16'd0);
        runGate("pulse_g3", 100, 1'b1, 2'd1, -1, 2'd0, 1'b1);
        idle(6);
        checkOutput("stop_busy", busy, 1'b0);

        // ch0 held high, ch2 toggling to saturation, random on ch1/ch3; full gate.
        mode[0] = 1; mode[1] = 3; mode[2] = 4; mode[3] = 3;
        startRun(2'd0);
        runGate("full_g1", 1000, 1'b0, 2'd0, -1, 2'd0, 1'b0);
        checkOutput("held_first", freq_data[7:0], 8'd1);
        checkOutput("sat_ch2", freq_data[23:16], 8'd255);
`ifdef FREQ_METER_OVF_EN
        checkOutput("ovf_set", ovf[2], 1'b1);
`endif
        runGate("full_g2", 1000, 1'b0, 2'd2, -1, 2'd0, 1'b1);
        checkOutput("held_next", freq_data[7:0], 8'd0);
        runGate("quiet_g3", 10, 1'b1, 2'd2, -1, 2'd0, 1'b0);
`ifdef FREQ_METER_OVF_EN
        checkOutput("ovf_clear", ovf[2], 1'b0);
`endif
        idle(4);

        // gate_sel changed mid-gate only affects the following gate.
        mode[0] = 3; mode[1] = 3; mode[2] = 2; per[2] = 3; mode[3] = 4;
        startRun(2'd1);
        runGate("selchg_g1", 100, 1'b0, 2'd2, 50, 2'd2, 1'b0);
        runGate("selchg_g2", 10, 1'b1, 2'd2, -1, 2'd0, 1'b0);
        idle(4);

        // Shortest gate: one cycle, back to back.
        startRun(2'd3);
        runGate("short_g1", 1, 1'b0, 2'd3, -1, 2'd0, 1'b0);
        runGate("short_g2", 1, 1'b0, 2'd3, -1, 2'd0, 1'b0);
        runGate("short_g3", 1, 1'b1, 2'd3, -1, 2'd0, 1'b0);
        idle(4);

        // Abort at cycle 50 of a 100-cycle gate.
        prev = last_exp;
        seen = 1'b0;
        startRun(2'd1);
        for (int k = 0; k <= 120; k++) begin
            @(negedge sys_clk);
            if (freq_valid) seen = 1'b1;
            if (k == 50) begin
                checkOutput("abort_busy_before", busy, 1'b1);
                run = 1'b0;
            end
            if (k == 52) checkOutput("abort_busy_after", busy, 1'b0);
            applyStimulus();
        end
        checkOutput("abort_no_valid", seen, 1'b0);
        checkOutput("abort_data_kept", freq_data, prev);

        // Reset pulse mid-gate, then a fresh gate after release.
        startRun(2'd1);
        idle(40);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst_data", freq_data, 32'd0);
        checkOutput("midrst_valid", freq_valid, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
`ifdef FREQ_METER_OVF_EN
        checkOutput("midrst_ovf", ovf, 4'd0);
`endif
        idle(3);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        gate_e    = cyc + 1;
        applyStimulus();
        runGate("after_rst", 100, 1'b1, 2'd1, -1, 2'd0, 1'b0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
